// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: scans enabled mux inputs 0..3 in ascending order, holding each sel for DWELL cycles and capturing y_in into sample; ports clk, rst, start, mask, y_in -> sel, busy, done, sample
module mux_scan_ctrl #(
    parameter int DWELL = 2,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] mask,
    input  logic       y_in,
    output logic [1:0] sel,
    output logic       busy,
    output logic       done,
    output logic [3:0] sample
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0] sel_n, first, nxt;
    logic [3:0] mask_q, mask_n, sample_n;
    logic more;
    always_comb begin
        first = 2'd0;
        nxt = sel;
        more = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) first = 2'(i);
            if (mask_q[i] && i > int'(sel)) begin
                nxt = 2'(i);
                more = 1'b1;
            end
        end
    end
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        sel_n = sel;
        mask_n = mask_q;
        sample_n = sample;
        case (state)
            IDLE: if (start) begin
                sample_n = 4'b0000;
                if (|mask) begin
                    mask_n = mask;
                    sel_n = first;
                    cnt_n = '0;
                    state_n = SCAN;
                end else state_n = DONE;
            end
            SCAN: if (cnt == CNT_W'(DWELL - 1)) begin
                sample_n[sel] = y_in;
                cnt_n = '0;
                if (more) sel_n = nxt;
                else state_n = DONE;
            end else cnt_n = cnt + CNT_W'(1);
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            sel <= 2'd0;
            mask_q <= 4'b0000;
            sample <= 4'b0000;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            sel <= sel_n;
            mask_q <= mask_n;
            sample <= sample_n;
        end
    end
    assign busy = state == SCAN;
    assign done = state == DONE;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: directed self-checking bench for mux_scan_ctrl with a behavioural 4:1 mux on y_in
module tb_mux_scan_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [3:0] mask = 4'b0000;
    logic [3:0] mux_i = 4'b0000;
    logic y_in;
    logic [1:0] sel;
    logic busy, done;
    logic [3:0] sample;
    int checks = 0;
    int errors = 0;
    int dones;
    mux_scan_ctrl #(.DWELL(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .mask(mask), .y_in(y_in),
        .sel(sel), .busy(busy), .done(done), .sample(sample)
    );
    assign y_in = mux_i[sel];
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(negedge clk);
    endtask
    initial begin
        tick(); tick();
        chk("rst_sel", 8'(sel), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_done", 8'(done), 8'd0);
        chk("rst_sample", 8'(sample), 8'h0);
        rst = 1'b0;
        tick();
        chk("idle_busy", 8'(busy), 8'd0);
        // 1: full scan
        mux_i = 4'b1010; mask = 4'b1111; start = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            start = 1'b0;
            chk($sformatf("t1_sel%0d", k), 8'(sel), 8'(k / 2));
            chk($sformatf("t1_busy%0d", k), 8'(busy), 8'd1);
            chk($sformatf("t1_done%0d", k), 8'(done), 8'd0);
        end
        tick();
        chk("t1_done", 8'(done), 8'd1);
        chk("t1_dbusy", 8'(busy), 8'd0);
        chk("t1_sample", 8'(sample), 8'hA);
        tick();
        chk("t1_done_low", 8'(done), 8'd0);
        chk("t1_hold", 8'(sample), 8'hA);
        // 2: sparse mask
        mux_i = 4'b1111; mask = 4'b0101; start = 1'b1;
        tick(); start = 1'b0;
        chk("t2_sel_a", 8'(sel), 8'd0);
        chk("t2_clr", 8'(sample), 8'h0);
        tick();
        chk("t2_sel_b", 8'(sel), 8'd0);
        tick();
        chk("t2_sel_c", 8'(sel), 8'd2);
        tick();
        chk("t2_sel_d", 8'(sel), 8'd2);
        chk("t2_busy", 8'(busy), 8'd1);
        tick();
        chk("t2_done", 8'(done), 8'd1);
        chk("t2_sample", 8'(sample), 8'h5);
        tick();
        // 3: empty mask, and a start during DONE is ignored
        mask = 4'b0000; start = 1'b1;
        tick();
        chk("t3_done", 8'(done), 8'd1);
        chk("t3_busy", 8'(busy), 8'd0);
        chk("t3_sel", 8'(sel), 8'd2);
        chk("t3_sample", 8'(sample), 8'h0);
        mask = 4'b1111;
        tick(); start = 1'b0;
        chk("t3_done_low", 8'(done), 8'd0);
        chk("t3_ign_busy", 8'(busy), 8'd0);
        tick();
        chk("t3_still_idle", 8'(busy), 8'd0);
        // 4: start mid-scan ignored
        mux_i = 4'b1010; mask = 4'b1111; start = 1'b1;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            start = 1'b0;
            if (k == 2) begin start = 1'b1; mask = 4'b0001; end
            chk($sformatf("t4_sel%0d", k), 8'(sel), 8'(k / 2));
            if (done) dones++;
        end
        start = 1'b0;
        tick();
        chk("t4_done", 8'(done), 8'd1);
        chk("t4_sample", 8'(sample), 8'hA);
        if (done) dones++;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done) dones++;
        end
        chk("t4_pulses", 8'(dones), 8'd1);
        // 5: reset during channel 2 dwell
        mask = 4'b1111; start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            start = 1'b0;
        end
        chk("t5_pre_sel", 8'(sel), 8'd2);
        chk("t5_pre_sample", 8'(sample), 8'h2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_sel", 8'(sel), 8'd0);
        chk("t5_busy", 8'(busy), 8'd0);
        chk("t5_sample", 8'(sample), 8'h0);
        chk("t5_done", 8'(done), 8'd0);
        dones = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done) dones++;
        end
        chk("t5_no_done", 8'(dones), 8'd0);
        mux_i = 4'b0110; start = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            start = 1'b0;
        end
        tick();
        chk("t5_re_done", 8'(done), 8'd1);
        chk("t5_re_sample", 8'(sample), 8'h6);
        tick();
        // 6: back-to-back scans
        mux_i = 4'b1010; mask = 4'b1111; start = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            start = 1'b0;
        end
        tick();
        chk("t6_done_a", 8'(done), 8'd1);
        chk("t6_sample_a", 8'(sample), 8'hA);
        tick();
        chk("t6_held", 8'(sample), 8'hA);
        mux_i = 4'b0101; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_clr", 8'(sample), 8'h0);
        chk("t6_busy", 8'(busy), 8'd1);
        for (int k = 0; k < 7; k++) tick();
        tick();
        chk("t6_done_b", 8'(done), 8'd1);
        chk("t6_sample_b", 8'(sample), 8'h5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
